sweep_sequencer: RTL



---
 rtl/sweep_seq_pkg.sv | 37 +++
 rtl/sweep_seq_table.sv | 34 +++
 rtl/sweep_sequencer.sv | 206 ++++++++++++++++++++
 3 files changed

// File: rtl/sweep_seq_pkg.sv
// Shared definitions for the sweep segment sequencer: field widths,
// sweep mode codes, sequencer states and the segment table entry layout.
package sweep_seq_pkg;

  localparam int BASE_W  = 20;
  localparam int MODE_W  = 2;
  localparam int RANGE_W = 17;
  localparam int SPEED_W = 13;
  localparam int DWELL_W = 16;
  localparam int ENTRY_W = BASE_W + MODE_W + RANGE_W + SPEED_W + DWELL_W;

  // Base frequency presented to sweep_controller before any segment has run
  localparam logic [BASE_W-1:0] BASE_RST = 20'd100000;

  typedef enum logic [MODE_W-1:0] {
    SWEEP_NONE   = 2'b00,
    SWEEP_LINEAR = 2'b01,
    SWEEP_SINE   = 2'b10
  } sweep_mode_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_FETCH = 2'b01,
    ST_LOAD  = 2'b10,
    ST_RUN   = 2'b11
  } seq_state_e;

  // One segment as stored in the table (68 bits)
  typedef struct packed {
    logic [BASE_W-1:0]  base;
    logic [MODE_W-1:0]  mode;
    logic [RANGE_W-1:0] span;
    logic [SPEED_W-1:0] speed;
    logic [DWELL_W-1:0] dwell;
  } seg_entry_t;

endpackage

// File: rtl/sweep_seq_table.sv
// Segment table: DEPTH entries, one write port and one registered read port.
// A read and a write to the same entry in the same cycle return the old data.
module sweep_seq_table
  import sweep_seq_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  seg_entry_t    wr_data,
  input  logic          rd_en,
  input  logic [AW-1:0] rd_addr,
  output seg_entry_t    rd_data_p1
);

  seg_entry_t mem [DEPTH];

  // Table write, allowed in every sequencer state
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // Registered read; sees the array contents from before this edge's write
  always_ff @(posedge clk) begin
    if (rd_en) begin
      rd_data_p1 <= mem[rd_addr];
    end
  end

endmodule

// File: rtl/sweep_sequencer.sv
// Steps through a table of sweep segments and presents each segment's
// configuration to sweep_controller as one atomic update per segment.
module sweep_sequencer
  import sweep_seq_pkg::*;
#(
  parameter int DEPTH      = 8,
  parameter int CLK_PER_MS = 100000,
  parameter int AW         = $clog2(DEPTH)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               wr_en,
  input  logic [AW-1:0]      wr_addr,
  input  logic [BASE_W-1:0]  wr_base,
  input  logic [MODE_W-1:0]  wr_mode,
  input  logic [RANGE_W-1:0] wr_range,
  input  logic [SPEED_W-1:0] wr_speed,
  input  logic [DWELL_W-1:0] wr_dwell,
  input  logic [AW:0]        num_segments,
  input  logic               loop_en,
  input  logic               start,
  input  logic               stop,
  output logic [BASE_W-1:0]  base_freq_o,
  output logic [MODE_W-1:0]  sweep_mode_o,
  output logic [RANGE_W-1:0] sweep_range_o,
  output logic [SPEED_W-1:0] sweep_speed_o,
  output logic [AW-1:0]      seg_idx,
  output logic               busy,
  output logic               seg_start,
  output logic               done
);

  localparam int PW = (CLK_PER_MS > 1) ? $clog2(CLK_PER_MS) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(CLK_PER_MS - 1);
  localparam logic [AW:0]   DEPTH_CNT  = (AW+1)'(DEPTH);

  // Reserved mode code 11 is presented as "no sweep"
  function automatic logic [MODE_W-1:0] sat_mode(input logic [MODE_W-1:0] m);
    logic [MODE_W-1:0] r;
    r = m;
    if (m == 2'b11) begin
      r = SWEEP_NONE;
    end
    return r;
  endfunction

  // A zero dwell would never expire; run it as one ms instead
  function automatic logic [DWELL_W-1:0] sat_dwell(input logic [DWELL_W-1:0] d);
    return (d == '0) ? DWELL_W'(1) : d;
  endfunction

  // Segment count cannot exceed the table size
  function automatic logic [AW:0] clamp_count(input logic [AW:0] n);
    return (n > DEPTH_CNT) ? DEPTH_CNT : n;
  endfunction

  seq_state_e         state_q, state_d;
  logic [AW:0]        seg_cnt_q;
  logic [PW-1:0]      presc_q;
  logic [DWELL_W-1:0] dwell_q;
  seg_entry_t         wr_entry;
  seg_entry_t         rd_data_p1;
  logic               rd_en;
  logic               tick, seg_end, last_seg;
  logic               accept, load, run_step, adv, wrap, finish, abort;

  assign wr_entry = {wr_base, wr_mode, wr_range, wr_speed, wr_dwell};
  assign rd_en    = (state_q == ST_FETCH);
  assign busy     = (state_q != ST_IDLE);
  assign tick     = (presc_q == PRESC_LAST);
  assign seg_end  = tick && (dwell_q == DWELL_W'(1));
  assign last_seg = (({1'b0, seg_idx} + (AW+1)'(1)) == seg_cnt_q);

  sweep_seq_table #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_table (
    .clk        (clk),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_entry),
    .rd_en      (rd_en),
    .rd_addr    (seg_idx),
    .rd_data_p1 (rd_data_p1)
  );

  // Sequencer state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state and per-cycle actions; stop outranks start and segment advance
  always_comb begin
    state_d  = state_q;
    accept   = 1'b0;
    load     = 1'b0;
    run_step = 1'b0;
    adv      = 1'b0;
    wrap     = 1'b0;
    finish   = 1'b0;
    abort    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start && !stop && (num_segments != '0)) begin
          accept  = 1'b1;
          state_d = ST_FETCH;
        end
      end
      ST_FETCH: begin
        if (stop) begin
          abort   = 1'b1;
          state_d = ST_IDLE;
        end else begin
          state_d = ST_LOAD;
        end
      end
      ST_LOAD: begin
        if (stop) begin
          abort   = 1'b1;
          state_d = ST_IDLE;
        end else begin
          load    = 1'b1;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        if (stop) begin
          abort   = 1'b1;
          state_d = ST_IDLE;
        end else begin
          run_step = 1'b1;
          if (seg_end) begin
            if (!last_seg) begin
              adv     = 1'b1;
              state_d = ST_FETCH;
            end else if (loop_en) begin
              wrap    = 1'b1;
              state_d = ST_FETCH;
            end else begin
              finish  = 1'b1;
              state_d = ST_IDLE;
            end
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Output configuration, segment index, dwell timing and status pulses
  always_ff @(posedge clk) begin
    if (rst) begin
      base_freq_o   <= BASE_RST;
      sweep_mode_o  <= SWEEP_NONE;
      sweep_range_o <= '0;
      sweep_speed_o <= '0;
      seg_idx       <= '0;
      seg_cnt_q     <= '0;
      presc_q       <= '0;
      dwell_q       <= '0;
      seg_start     <= 1'b0;
      done          <= 1'b0;
    end else begin
      seg_start <= load;
      done      <= finish;
      if (accept) begin
        seg_idx   <= '0;
        seg_cnt_q <= clamp_count(num_segments);
      end
      // --- stage p1 -> outputs: table read data becomes the live config ---
      if (load) begin
        base_freq_o   <= rd_data_p1.base;
        sweep_mode_o  <= sat_mode(rd_data_p1.mode);
        sweep_range_o <= rd_data_p1.span;
        sweep_speed_o <= rd_data_p1.speed;
        dwell_q       <= sat_dwell(rd_data_p1.dwell);
        presc_q       <= '0;
      end
      if (run_step) begin
        if (tick) begin
          presc_q <= '0;
          dwell_q <= dwell_q - DWELL_W'(1);
        end else begin
          presc_q <= presc_q + PW'(1);
        end
      end
      if (adv) begin
        seg_idx <= seg_idx + AW'(1);
      end
      if (wrap) begin
        seg_idx <= '0;
      end
      // Leaving for IDLE quiets the sweep but keeps the last base frequency
      if (finish || abort) begin
        sweep_mode_o  <= SWEEP_NONE;
        sweep_range_o <= '0;
        sweep_speed_o <= '0;
      end
    end
  end

endmodule
